execute_stage_control: RTL

Pipeline-control block for the decode→execute boundary. It produces `stall_out`, `execution_empty_out` and `set_nop_out`, the stall, execute-empty and bubble-insert controls that the decode/execute register consumes. It tracks what the register has handed to execute: multi-cycle multiplies, data-cache accesses and load results pending writeback. From that state it decides when the next decoded instruction may advance, when a bubble (NOP) must be inserted, and when execute is empty.

---
 rtl/execute_stage_control_if.sv | 36 +++
 rtl/execute_stage_control.sv | 111 +++++++++++
 2 files changed

// File: rtl/execute_stage_control_if.sv
// Decode/execute boundary signals between the decode stage and execute_stage_control.
// dbg_* expose the controller's internal state for observation.
interface execute_stage_control_if #(
  parameter int REGISTER_INDEX_WIDTH = 5
);
  logic                            id_valid;
  logic [REGISTER_INDEX_WIDTH-1:0] id_src1;
  logic [REGISTER_INDEX_WIDTH-1:0] id_src2;
  logic [REGISTER_INDEX_WIDTH-1:0] id_dst;
  logic                            id_reg_write;
  logic                            id_mem_to_reg;
  logic                            id_d_cache_access;
  logic                            id_is_mul;
  logic                            dcache_ready;
  logic                            branch_taken;
  logic                            stall_out;
  logic                            execution_empty_out;
  logic                            set_nop_out;
  logic                            mul_done_out;
  logic [1:0]                      dbg_state;
  logic                            dbg_load_pending;

  modport master (
    output id_valid, id_src1, id_src2, id_dst, id_reg_write, id_mem_to_reg,
           id_d_cache_access, id_is_mul, dcache_ready, branch_taken,
    input  stall_out, execution_empty_out, set_nop_out, mul_done_out,
           dbg_state, dbg_load_pending
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_dst, id_reg_write, id_mem_to_reg,
           id_d_cache_access, id_is_mul, dcache_ready, branch_taken,
    output stall_out, execution_empty_out, set_nop_out, mul_done_out,
           dbg_state, dbg_load_pending
  );
endinterface

// File: rtl/execute_stage_control.sv
// Stall / bubble / execute-empty control for the decode->execute register.
// Tracks in-flight multiplies, d-cache accesses and a pending load result; state moves on negedge.
module execute_stage_control #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int MUL_LATENCY          = 5
) (
  input logic                    clk,
  input logic                    rst_n,
  execute_stage_control_if.slave bus
);
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MUL   = 2'd1,
    S_MEM   = 2'd2
  } state_t;

  localparam logic [3:0] MUL_INIT = 4'(MUL_LATENCY - 1);

  state_t                          r_state, w_state_nxt;
  logic [3:0]                      r_cnt, w_cnt_nxt;
  logic                            r_load_pending, w_pending_nxt;
  logic                            r_load_armed, w_armed_nxt;
  logic [REGISTER_INDEX_WIDTH-1:0] r_load_dst, w_dst_nxt;
  logic                            r_mul_done, w_mul_done_nxt;

  logic w_empty, w_hit, w_load_use, w_set_nop, w_stall, w_accept, w_is_load;

  // Handshake: an instruction moves into execute at a negedge only when id_valid is high
  // and the block shows empty with neither stall nor bubble; otherwise decode holds it.
  always_comb begin
    w_empty    = (r_state == S_EMPTY);
    w_hit      = bus.id_valid & (r_load_dst != '0) &
                 ((bus.id_src1 == r_load_dst) | (bus.id_src2 == r_load_dst));
    w_load_use = r_load_pending & w_hit;
    w_set_nop  = w_empty & (bus.branch_taken | w_load_use);
    w_stall    = ~w_empty | (w_load_use & ~bus.branch_taken);
    w_accept   = bus.id_valid & ~w_stall & w_empty & ~w_set_nop;
    w_is_load  = bus.id_mem_to_reg & bus.id_reg_write & (bus.id_dst != '0);
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_pending_nxt  = r_load_pending;
    w_armed_nxt    = r_load_armed;
    w_dst_nxt      = r_load_dst;
    w_mul_done_nxt = 1'b0;
    case (r_state)
      S_EMPTY: begin
        // A pending load result is only visible for a single EMPTY cycle.
        w_pending_nxt = 1'b0;
        if (w_accept) begin
          if (bus.id_is_mul) begin
            w_state_nxt = S_MUL;
            w_cnt_nxt   = MUL_INIT;
          end else if (bus.id_d_cache_access) begin
            w_state_nxt = S_MEM;
          end
          if (w_is_load) begin
            w_dst_nxt = bus.id_dst;
            if (bus.id_is_mul | bus.id_d_cache_access) w_armed_nxt   = 1'b1;
            else                                       w_pending_nxt = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt    = S_EMPTY;
          w_mul_done_nxt = 1'b1;
          w_pending_nxt  = r_load_armed;
          w_armed_nxt    = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_MEM: begin
        if (bus.dcache_ready) begin
          w_state_nxt   = S_EMPTY;
          w_pending_nxt = r_load_armed;
          w_armed_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_EMPTY;
      r_cnt          <= 4'd0;
      r_load_pending <= 1'b0;
      r_load_armed   <= 1'b0;
      r_load_dst     <= '0;
      r_mul_done     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_load_pending <= w_pending_nxt;
      r_load_armed   <= w_armed_nxt;
      r_load_dst     <= w_dst_nxt;
      r_mul_done     <= w_mul_done_nxt;
    end
  end

  assign bus.stall_out           = w_stall;
  assign bus.execution_empty_out = w_empty;
  assign bus.set_nop_out         = w_set_nop;
  assign bus.mul_done_out        = r_mul_done;
  assign bus.dbg_state           = r_state;
  assign bus.dbg_load_pending    = r_load_pending;
endmodule
